// File: rtl/shift_serdes.sv
// Shift-register serializer/deserializer with valid/ready word intake and gapless back-to-back words.
// Optional build macro SHIFT_SERDES_LOOPBACK_EN routes o_ser_out into the receive path.
module shift_serdes #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_par_valid,
    output logic             o_par_ready,
    input  logic [WIDTH-1:0] i_par_in,
    input  logic             i_ser_in,
    output logic             o_ser_out,
    output logic             o_ser_en,
    output logic [WIDTH-1:0] o_par_out,
    output logic             o_par_out_valid,
    output logic             o_busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic [WIDTH-1:0]   rx_q, rx_d;
    logic [WIDTH-1:0]   pout_q, pout_d;
    logic               pvld_q, pvld_d;

    logic               shifting, last, accept, tx_bit, rx_bit;
    logic [WIDTH-1:0]   tx_shift, rx_shift;

    assign shifting    = (state_q == SHIFT);
    assign last        = shifting && (cnt_q == CNT_LAST);
    assign o_par_ready = (state_q == IDLE) || last;
    assign accept      = i_par_valid && o_par_ready;

    assign tx_bit      = MSB_FIRST ? tx_q[WIDTH-1] : tx_q[0];
    assign o_ser_out   = shifting & tx_bit;
    assign o_ser_en    = shifting;
    assign o_busy      = shifting;

`ifdef SHIFT_SERDES_LOOPBACK_EN
    logic unused_ser_in;
    assign unused_ser_in = i_ser_in;
    assign rx_bit        = o_ser_out;
`else
    assign rx_bit        = i_ser_in;
`endif

    // Both registers move toward the outgoing/incoming end selected by MSB_FIRST.
    assign tx_shift = MSB_FIRST ? {tx_q[WIDTH-2:0], 1'b0} : {1'b0, tx_q[WIDTH-1:1]};
    assign rx_shift = MSB_FIRST ? {rx_q[WIDTH-2:0], rx_bit} : {rx_bit, rx_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        pout_d  = pout_q;
        pvld_d  = 1'b0;
        if (i_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = '0;
            rx_d    = '0;
        end else begin
            if (shifting) begin
                tx_d  = tx_shift;
                rx_d  = rx_shift;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    pout_d  = rx_shift;
                    pvld_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            // A reload on the final bit edge restarts immediately without an idle cycle.
            if (accept) begin
                tx_d    = i_par_in;
                cnt_d   = '0;
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            pout_q  <= '0;
            pvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            pout_q  <= pout_d;
            pvld_q  <= pvld_d;
        end
    end

    assign o_par_out       = pout_q;
    assign o_par_out_valid = pvld_q;
endmodule

// File: tb/tb_shift_serdes.sv
// Bench for shift_serdes: LSB-first (index 0) and MSB-first (index 1) instances on shared stimulus,
// checked against a bit-position transaction model; honours SHIFT_SERDES_LOOPBACK_EN.
module tb_shift_serdes;
    localparam int W = 8;

    logic         clk = 1'b0, rstn = 1'b0, clr = 1'b0, pvin = 1'b0, serin = 1'b0;
    logic [W-1:0] parin = '0;
    logic [1:0]   rdy, sout, sen, bsy, vld;
    logic [W-1:0] pout [2];

    always #5 clk = ~clk;

    shift_serdes #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_par_valid(pvin), .o_par_ready(rdy[0]),
        .i_par_in(parin), .i_ser_in(serin), .o_ser_out(sout[0]), .o_ser_en(sen[0]),
        .o_par_out(pout[0]), .o_par_out_valid(vld[0]), .o_busy(bsy[0]));
    shift_serdes #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_par_valid(pvin), .o_par_ready(rdy[1]),
        .i_par_in(parin), .i_ser_in(serin), .o_ser_out(sout[1]), .o_ser_en(sen[1]),
        .o_par_out(pout[1]), .o_par_out_valid(vld[1]), .o_busy(bsy[1]));

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: a word in flight is described by its bit position; received bits are kept by stream order.
    bit           mb [2];
    int           mpos [2];
    logic [W-1:0] mword [2], mout [2];
    bit           mvld [2];
    bit           mrx [2][W];

    function automatic logic exp_sout(input int m);
        if (!mb[m]) return 1'b0;
        return mword[m][(m == 1) ? (W - 1 - mpos[m]) : mpos[m]];
    endfunction

    function automatic logic exp_ready(input int m);
        return !mb[m] || (mpos[m] == W - 1);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mb[m] = 0; mpos[m] = 0; mvld[m] = 0; mout[m] = '0; mword[m] = '0;
        end
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic s, input logic c);
        for (int m = 0; m < 2; m++) begin
            logic rdy_e, rb;
            rdy_e = exp_ready(m);
`ifdef SHIFT_SERDES_LOOPBACK_EN
            rb = exp_sout(m);
`else
            rb = s;
`endif
            mvld[m] = 0;
            if (c) begin
                mb[m] = 0; mpos[m] = 0;
            end else begin
                if (mb[m]) begin
                    mrx[m][mpos[m]] = rb;
                    if (mpos[m] == W - 1) begin
                        for (int i = 0; i < W; i++) mout[m][(m == 1) ? (W - 1 - i) : i] = mrx[m][i];
                        mvld[m] = 1;
                    end
                end
                if (v && rdy_e) begin
                    mb[m] = 1; mpos[m] = 0; mword[m] = d;
                end else if (mb[m]) begin
                    if (mpos[m] == W - 1) mb[m] = 0;
                    else mpos[m]++;
                end
            end
        end
    endtask

    logic [1:0]   s_sout, s_sen, s_bsy, s_vld;
    logic [W-1:0] s_pout [2];

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("ready%0d", m), 32'(rdy[m]), 32'(exp_ready(m)));
            chk($sformatf("ser_out%0d", m), 32'(sout[m]), 32'(exp_sout(m)));
            chk($sformatf("ser_en%0d", m), 32'(sen[m]), 32'(mb[m]));
            chk($sformatf("busy%0d", m), 32'(bsy[m]), 32'(mb[m]));
            chk($sformatf("par_out%0d", m), 32'(pout[m]), 32'(mout[m]));
            chk($sformatf("par_valid%0d", m), 32'(vld[m]), 32'(mvld[m]));
        end
    endtask

    // One clock cycle: drive after the rising edge, compare on the falling edge, advance model on the next rise.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic s, input logic c);
        pvin = v; parin = d; serin = s; clr = c;
        @(negedge clk);
        check_outputs();
        s_sout = sout; s_sen = sen; s_bsy = bsy; s_vld = vld;
        s_pout[0] = pout[0]; s_pout[1] = pout[1];
        @(posedge clk);
        model_step(v, d, s, c);
        #1;
    endtask

    task automatic reset_mid();
        pvin = 0; clr = 0;
        #2 rstn = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_ready%0d", m), 32'(rdy[m]), 32'd1);
            chk($sformatf("rst_ser_out%0d", m), 32'(sout[m]), 32'd0);
            chk($sformatf("rst_ser_en%0d", m), 32'(sen[m]), 32'd0);
            chk($sformatf("rst_busy%0d", m), 32'(bsy[m]), 32'd0);
            chk($sformatf("rst_par_out%0d", m), 32'(pout[m]), 32'd0);
            chk($sformatf("rst_valid%0d", m), 32'(vld[m]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] rxw;
        logic [W-1:0] exp_msb;
        logic [W-1:0] exp_lsb;
    } vec_t;
    vec_t tbl [4];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] cap0, cap1, prev0, prev1;
        int en_cnt, np, p1, p2;

`ifdef SHIFT_SERDES_LOOPBACK_EN
        tbl[0] = '{8'hA5, 8'h3C, 8'hA5, 8'hA5};
        tbl[1] = '{8'h01, 8'h01, 8'h01, 8'h01};
        tbl[2] = '{8'hC3, 8'hF0, 8'hC3, 8'hC3};
        tbl[3] = '{8'h5A, 8'h96, 8'h5A, 8'h5A};
`else
        tbl[0] = '{8'hA5, 8'h3C, 8'h3C, 8'h3C};
        tbl[1] = '{8'h01, 8'h01, 8'h01, 8'h80};
        tbl[2] = '{8'hC3, 8'hF0, 8'hF0, 8'h0F};
        tbl[3] = '{8'h5A, 8'h96, 8'h96, 8'h69};
`endif
        model_reset();
        #12 rstn = 1'b1;
        @(posedge clk); #1;

        // Directed words: serial image of d, received word from the rx stream driven MSB of rxw first.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, tbl[k].d, 1'b0, 1'b0);
            for (int i = 0; i < W; i++) begin
                cyc(1'b0, 8'h00, tbl[k].rxw[W-1-i], 1'b0);
                cap1[W-1-i] = s_sout[1];
                cap0[i]     = s_sout[0];
            end
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_ser_msb", k), 32'(cap1), 32'(tbl[k].d));
            chk($sformatf("tbl%0d_ser_lsb", k), 32'(cap0), 32'(tbl[k].d));
            chk($sformatf("tbl%0d_par_msb", k), 32'(s_pout[1]), 32'(tbl[k].exp_msb));
            chk($sformatf("tbl%0d_par_lsb", k), 32'(s_pout[0]), 32'(tbl[k].exp_lsb));
            chk($sformatf("tbl%0d_pulse", k), 32'(s_vld), 32'd3);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_pulse_end", k), 32'(s_vld), 32'd0);
        end

        // Back-to-back words with valid held.
        en_cnt = 0; np = 0; p1 = -1; p2 = -1;
        for (int t = 0; t < 20; t++) begin
            cyc(t <= 8, (t == 0) ? 8'hA5 : 8'h5A, 1'($urandom_range(0, 1)), 1'b0);
            en_cnt += int'(s_sen[1]);
            if (s_vld[1]) begin
                np++;
                if (p1 < 0) p1 = t; else p2 = t;
            end
        end
        chk("b2b_en_cycles", 32'(en_cnt), 32'd16);
        chk("b2b_pulses", 32'(np), 32'd2);
        chk("b2b_first_latency", 32'(p1), 32'(W + 1));
        chk("b2b_gap", 32'(p2 - p1), 32'(W));

        // Clear at cnt==3 with valid asserted.
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        prev0 = s_pout[0]; prev1 = s_pout[1];
        cyc(1'b1, 8'h5A, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr3_busy", 32'(s_bsy), 32'd0);
        chk("clr3_ser_en", 32'(s_sen), 32'd0);
        chk("clr3_ser_out", 32'(s_sout), 32'd0);
        chk("clr3_par_msb", 32'(s_pout[1]), 32'(prev1));
        chk("clr3_par_lsb", 32'(s_pout[0]), 32'(prev0));
        np = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            np += int'(s_vld[0]) + int'(s_vld[1]);
        end
        chk("clr3_no_pulse", 32'(np), 32'd0);

        // Clear on the final bit while a reload is offered: clear wins.
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < W - 1; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr7_busy", 32'(s_bsy), 32'd0);
        chk("clr7_valid", 32'(s_vld), 32'd0);

        // Asynchronous reset mid-word at cnt==3.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        reset_mid();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with occasional clears.
        for (int t = 0; t < 500; t++)
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom()), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 40) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
